// File: rtl/wisc_sc15_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// Single-beat reads: request is held until the memory acknowledges with data.
interface wisc_sc15_fetch_if;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_ack;
    logic [15:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/wisc_sc15_fetch.sv
// Fetch stage for the WISC-SC15 core: fetches one instruction, holds it for
// execute until retirement, then resolves the next PC (RET/CALL/branch/seq).
module wisc_sc15_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    wisc_sc15_fetch_if.master        im_bus,
    output logic [15:0]              instr,
    output logic                     instr_valid,
    output logic [15:0]              pc_plus1,
    input  logic                     ex_done,
    input  logic                     pc_src,
    input  logic                     sel_call,
    input  logic                     sel_branch,
    input  logic                     br_taken,
    input  logic [15:0]              ret_addr,
    output logic                     halted,
    output logic [15:0]              instr_count
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic [15:0] call_off;
    logic [15:0] br_off;
    logic        is_halt;

    assign pc_plus1 = pc + 16'd1;
    assign call_off = {{4{instr[11]}}, instr[11:0]};
    assign br_off   = {{8{instr[7]}}, instr[7:0]};
    assign is_halt  = (instr[15:12] == 4'b1111);

    // RET beats CALL beats taken branch; an untaken branch falls through.
    always_comb begin
        next_pc = pc_plus1;
        if (pc_src)
            next_pc = ret_addr;
        else if (sel_call)
            next_pc = pc_plus1 + call_off;
        else if (sel_branch && br_taken)
            next_pc = pc_plus1 + br_off;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= S_FETCH;
            instr       <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (im_bus.im_ack) begin
                        instr <= im_bus.im_rdata;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ex_done) begin
                        pc          <= next_pc;
                        instr_count <= instr_count + 16'd1;
                        state       <= is_halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by rst so it drops in the same cycle reset is applied.
    assign im_bus.im_req  = (state == S_FETCH) && !rst;
    assign im_bus.im_addr = pc;
    assign instr_valid    = (state == S_HOLD);
    assign halted         = (state == S_HALTED);

endmodule

// File: tb/tb_wisc_sc15_fetch.sv
// Directed, table-driven bench for wisc_sc15_fetch with hand-computed PCs.
module tb_wisc_sc15_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus1;
    logic        ex_done;
    logic        pc_src;
    logic        sel_call;
    logic        sel_branch;
    logic        br_taken;
    logic [15:0] ret_addr;
    logic        halted;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    wisc_sc15_fetch_if im_bus ();

    wisc_sc15_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_bus      (im_bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus1    (pc_plus1),
        .ex_done     (ex_done),
        .pc_src      (pc_src),
        .sel_call    (sel_call),
        .sel_branch  (sel_branch),
        .br_taken    (br_taken),
        .ret_addr    (ret_addr),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
        logic        pc_src;
        logic        sel_call;
        logic        sel_branch;
        logic        br_taken;
        logic [15:0] ret_addr;
        logic [15:0] next_pc;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        ex_done    = 1'b0;
        pc_src     = 1'b0;
        sel_call   = 1'b0;
        sel_branch = 1'b0;
        br_taken   = 1'b0;
        ret_addr   = 16'h0000;
    endtask

    // Entered at the start of a FETCH cycle; leaves at the start of the next one.
    task automatic run_vec(input int idx, input vec_t v);
        #1;
        check($sformatf("v%0d fetch im_req", idx), {15'd0, im_bus.im_req}, 16'd1);
        check($sformatf("v%0d fetch im_addr", idx), im_bus.im_addr, v.pc);
        check($sformatf("v%0d fetch instr_valid", idx), {15'd0, instr_valid}, 16'd0);
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = v.word;
        tick();
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = 16'hDEAD;
        check($sformatf("v%0d hold instr", idx), instr, v.word);
        check($sformatf("v%0d hold instr_valid", idx), {15'd0, instr_valid}, 16'd1);
        check($sformatf("v%0d hold im_req", idx), {15'd0, im_bus.im_req}, 16'd0);
        check($sformatf("v%0d hold pc_plus1", idx), pc_plus1, v.pc + 16'd1);
        ex_done    = 1'b1;
        pc_src     = v.pc_src;
        sel_call   = v.sel_call;
        sel_branch = v.sel_branch;
        br_taken   = v.br_taken;
        ret_addr   = v.ret_addr;
        tick();
        clear_ctrl();
        check($sformatf("v%0d next im_addr", idx), im_bus.im_addr, v.next_pc);
        check($sformatf("v%0d instr_count", idx), instr_count, 16'(idx + 1));
        check($sformatf("v%0d valid dropped", idx), {15'd0, instr_valid}, 16'd0);
    endtask

    initial begin
        //          pc        word      src   call  br    tkn   ret       next
        vecs[0]  = '{16'h0000, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001};
        vecs[1]  = '{16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010};
        vecs[2]  = '{16'h0010, 16'hC0FE, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h000F};
        vecs[3]  = '{16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010};
        vecs[4]  = '{16'h0010, 16'hC0FE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0011};
        vecs[5]  = '{16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0020};
        vecs[6]  = '{16'h0020, 16'hD800, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hF821};
        vecs[7]  = '{16'hF821, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0021};
        vecs[8]  = '{16'h0021, 16'h0105, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0127};
        vecs[9]  = '{16'h0127, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[10] = '{16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        rst             = 1'b1;
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = 16'h0000;
        clear_ctrl();
        tick();
        tick();
        check("reset im_req", {15'd0, im_bus.im_req}, 16'd0);
        check("reset instr", instr, 16'h0000);
        check("reset instr_valid", {15'd0, instr_valid}, 16'd0);
        check("reset halted", {15'd0, halted}, 16'd0);
        check("reset instr_count", instr_count, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Halt: retire 16'hF000, then everything but rst is ignored.
        #1;
        check("halt fetch im_addr", im_bus.im_addr, 16'h0000);
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = 16'hF000;
        tick();
        im_bus.im_ack = 1'b0;
        ex_done = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("halt c%0d halted", c), {15'd0, halted}, 16'd1);
            check($sformatf("halt c%0d im_req", c), {15'd0, im_bus.im_req}, 16'd0);
            check($sformatf("halt c%0d instr_valid", c), {15'd0, instr_valid}, 16'd0);
            check($sformatf("halt c%0d instr_count", c), instr_count, 16'h000C);
            check($sformatf("halt c%0d instr", c), instr, 16'hF000);
            ex_done         = 1'b1;
            pc_src          = 1'b1;
            ret_addr        = 16'h4444;
            im_bus.im_ack   = 1'b1;
            im_bus.im_rdata = 16'h9999;
            tick();
        end
        clear_ctrl();
        im_bus.im_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("post-halt halted", {15'd0, halted}, 16'd0);
        check("post-halt im_req", {15'd0, im_bus.im_req}, 16'd1);
        check("post-halt im_addr", im_bus.im_addr, RST_PC);
        check("post-halt instr_count", instr_count, 16'h0000);

        // Memory wait of 3 cycles; stray ex_done/redirects in FETCH ignored.
        for (int c = 0; c < 4; c++) begin
            check($sformatf("wait c%0d im_req", c), {15'd0, im_bus.im_req}, 16'd1);
            check($sformatf("wait c%0d im_addr", c), im_bus.im_addr, RST_PC);
            check($sformatf("wait c%0d instr_valid", c), {15'd0, instr_valid}, 16'd0);
            check($sformatf("wait c%0d instr_count", c), instr_count, 16'h0000);
            ex_done  = 1'b1;
            pc_src   = 1'b1;
            ret_addr = 16'hAAAA;
            if (c == 3) begin
                clear_ctrl();
                im_bus.im_ack   = 1'b1;
                im_bus.im_rdata = 16'h0042;
            end
            tick();
        end
        im_bus.im_ack = 1'b0;
        check("wait captured instr", instr, 16'h0042);

        // Stalled HOLD with im_ack pulses that must not disturb instr.
        for (int c = 0; c < 5; c++) begin
            im_bus.im_ack   = c[0];
            im_bus.im_rdata = 16'hBEEF;
            tick();
            check($sformatf("stall c%0d instr", c), instr, 16'h0042);
            check($sformatf("stall c%0d instr_valid", c), {15'd0, instr_valid}, 16'd1);
            check($sformatf("stall c%0d im_addr", c), im_bus.im_addr, RST_PC);
        end
        im_bus.im_ack = 1'b0;
        ex_done = 1'b1;
        tick();
        clear_ctrl();
        check("stall retire im_addr", im_bus.im_addr, RST_PC + 16'd1);
        check("stall retire count", instr_count, 16'h0001);

        // Reset during an outstanding FETCH; a late ack lands at RESET_PC.
        tick();
        rst             = 1'b1;
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = 16'h7777;
        #1;
        check("rst mid-fetch im_req", {15'd0, im_bus.im_req}, 16'd0);
        tick();
        rst             = 1'b0;
        im_bus.im_rdata = 16'h5555;
        #1;
        check("rst mid-fetch instr", instr, 16'h0000);
        check("rst mid-fetch im_addr", im_bus.im_addr, RST_PC);
        check("rst mid-fetch count", instr_count, 16'h0000);
        check("rst mid-fetch im_req after", {15'd0, im_bus.im_req}, 16'd1);
        tick();
        im_bus.im_ack = 1'b0;
        check("late ack instr", instr, 16'h5555);
        check("late ack instr_valid", {15'd0, instr_valid}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
